// File: rtl/mips_cpu_pkg.sv
// Shared types and sizes for the writeback path.
//   REG_IDX_W  : architectural register index width
//   DATA_W     : register data width
//   NUM_REGS   : number of architectural registers
//   wb_entry_t : one pending register-file write {destination, data}
package mips_cpu_pkg;

  localparam int unsigned REG_IDX_W = 5;
  localparam int unsigned DATA_W    = 32;
  localparam int unsigned NUM_REGS  = 32;

  typedef struct packed {
    logic [REG_IDX_W-1:0] rd;
    logic [DATA_W-1:0]    data;
  } wb_entry_t;

endpackage

// File: rtl/wb_fifo.sv
// Synchronous FIFO of writeback entries, first-word fall-through on rdata_o.
// Ports:
//   clk_i, rst_ni : clock, synchronous active-low reset
//   push_i/wdata_i: enqueue request (dropped when full)
//   pop_i/rdata_o : dequeue request (dropped when empty) / head entry
//   full_o, empty_o, count_o : occupancy, all from registered state
module wb_fifo
  import mips_cpu_pkg::*;
#(
  parameter int unsigned Depth = 2
) (
  input  logic                     clk_i,
  input  logic                     rst_ni,
  input  logic                     push_i,
  input  wb_entry_t                wdata_i,
  input  logic                     pop_i,
  output wb_entry_t                rdata_o,
  output logic                     full_o,
  output logic                     empty_o,
  output logic [$clog2(Depth):0]   count_o
);

  localparam int unsigned PtrW = $clog2(Depth);

  wb_entry_t         mem_q [Depth];
  logic [PtrW-1:0]   wptr_q, rptr_q;
  logic [PtrW:0]     count_q, count_d;
  logic              push_ok, pop_ok;

  assign full_o  = (count_q == (PtrW+1)'(Depth));
  assign empty_o = (count_q == '0);
  assign count_o = count_q;
  assign rdata_o = mem_q[rptr_q];

  assign push_ok = push_i & ~full_o;
  assign pop_ok  = pop_i & ~empty_o;

  always_comb begin
    count_d = count_q;
    unique case ({push_ok, pop_ok})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  // Pointers wrap naturally because Depth is a power of two.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
    end else begin
      if (push_ok) wptr_q <= wptr_q + 1'b1;
      if (pop_ok)  rptr_q <= rptr_q + 1'b1;
      count_q <= count_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (push_ok) mem_q[wptr_q] <= wdata_i;
  end

endmodule

// File: rtl/writeback_sequencer.sv
// Merges the ALU result channel (ch0, always accepted, highest priority) and the
// load/mult channel (ch1, buffered in a FIFO) into a single registered
// register-file write port, and tracks outstanding destinations for hazard checks.
// Ports:
//   clk, reset (sync, active-low)
//   ch0_valid/ch0_reg/ch0_data            : ALU results
//   ch1_valid/ch1_ready/ch1_reg/ch1_data  : load/mult results, valid/ready
//   reserve_valid/reserve_reg             : issue-time destination reservation
//   check_index1/2 -> busy1/2             : hazard query
//   write_enable/write_reg/write_data     : register-file write drive
//   idle                                  : nothing buffered, in flight or pending
module writeback_sequencer
  import mips_cpu_pkg::*;
#(
  parameter int unsigned FIFO_DEPTH = 2
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 ch0_valid,
  input  logic [REG_IDX_W-1:0] ch0_reg,
  input  logic [DATA_W-1:0]    ch0_data,
  input  logic                 ch1_valid,
  output logic                 ch1_ready,
  input  logic [REG_IDX_W-1:0] ch1_reg,
  input  logic [DATA_W-1:0]    ch1_data,
  input  logic                 reserve_valid,
  input  logic [REG_IDX_W-1:0] reserve_reg,
  input  logic [REG_IDX_W-1:0] check_index1,
  input  logic [REG_IDX_W-1:0] check_index2,
  output logic                 busy1,
  output logic                 busy2,
  output logic                 write_enable,
  output logic [REG_IDX_W-1:0] write_reg,
  output logic [DATA_W-1:0]    write_data,
  output logic                 idle
);

  localparam int unsigned CntW = $clog2(FIFO_DEPTH) + 1;

  wb_entry_t            fifo_head, fifo_wdata, sel_entry;
  logic                 fifo_push, fifo_pop, fifo_full, fifo_empty;
  logic [CntW-1:0]      fifo_count;
  logic                 sel_valid;

  logic                 we_q, we_d;
  logic [REG_IDX_W-1:0] wreg_q, wreg_d;
  logic [DATA_W-1:0]    wdata_q, wdata_d;
  logic [NUM_REGS-1:0]  pending_q, pending_d;

  assign ch1_ready       = ~fifo_full;
  assign fifo_push       = reset & ch1_valid & ch1_ready;
  assign fifo_wdata.rd   = ch1_reg;
  assign fifo_wdata.data = ch1_data;

  wb_fifo #(
    .Depth (FIFO_DEPTH)
  ) u_fifo (
    .clk_i   (clk),
    .rst_ni  (reset),
    .push_i  (fifo_push),
    .wdata_i (fifo_wdata),
    .pop_i   (fifo_pop),
    .rdata_o (fifo_head),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .count_o (fifo_count)
  );

  // Source select: ch0 wins; the FIFO head only drains on ch0-idle cycles.
  always_comb begin
    sel_valid = 1'b0;
    fifo_pop  = 1'b0;
    sel_entry = fifo_head;
    if (ch0_valid) begin
      sel_valid      = 1'b1;
      sel_entry.rd   = ch0_reg;
      sel_entry.data = ch0_data;
    end else if (!fifo_empty) begin
      sel_valid = 1'b1;
      fifo_pop  = 1'b1;
    end
  end

  always_comb begin
    we_d      = sel_valid & (sel_entry.rd != '0);
    wreg_d    = wreg_q;
    wdata_d   = wdata_q;
    pending_d = pending_q;
    if (sel_valid) begin
      wreg_d  = sel_entry.rd;
      wdata_d = sel_entry.data;
      pending_d[sel_entry.rd] = 1'b0;
    end
    // Reservation applied after the clear so a same-cycle reserve wins.
    if (reserve_valid && reserve_reg != '0) pending_d[reserve_reg] = 1'b1;
    pending_d[0] = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      we_q      <= 1'b0;
      wreg_q    <= '0;
      wdata_q   <= '0;
      pending_q <= '0;
    end else begin
      we_q      <= we_d;
      wreg_q    <= wreg_d;
      wdata_q   <= wdata_d;
      pending_q <= pending_d;
    end
  end

  assign write_enable = we_q;
  assign write_reg    = wreg_q;
  assign write_data   = wdata_q;

  // A write sitting in the output stage still counts as busy until it retires.
  assign busy1 = (check_index1 != '0) &&
                 (pending_q[check_index1] || (we_q && wreg_q == check_index1));
  assign busy2 = (check_index2 != '0) &&
                 (pending_q[check_index2] || (we_q && wreg_q == check_index2));

  assign idle = (fifo_count == '0) && !we_q && (pending_q == '0);

endmodule

// File: tb/tb_writeback_sequencer.sv
module tb_writeback_sequencer;

  logic        clk = 1'b0;
  logic        reset;
  logic        ch0_valid, ch1_valid, reserve_valid;
  logic [4:0]  ch0_reg, ch1_reg, reserve_reg, check_index1, check_index2;
  logic [31:0] ch0_data, ch1_data;
  logic        ch1_ready, busy1, busy2, write_enable, idle;
  logic [4:0]  write_reg;
  logic [31:0] write_data;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  writeback_sequencer #(
    .FIFO_DEPTH (2)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .ch0_valid     (ch0_valid),
    .ch0_reg       (ch0_reg),
    .ch0_data      (ch0_data),
    .ch1_valid     (ch1_valid),
    .ch1_ready     (ch1_ready),
    .ch1_reg       (ch1_reg),
    .ch1_data      (ch1_data),
    .reserve_valid (reserve_valid),
    .reserve_reg   (reserve_reg),
    .check_index1  (check_index1),
    .check_index2  (check_index2),
    .busy1         (busy1),
    .busy2         (busy2),
    .write_enable  (write_enable),
    .write_reg     (write_reg),
    .write_data    (write_data),
    .idle          (idle)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Advance past the next rising edge; outputs are then settled.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset = 1'b0;
    ch0_valid = 0; ch0_reg = 0; ch0_data = 0;
    ch1_valid = 0; ch1_reg = 0; ch1_data = 0;
    reserve_valid = 0; reserve_reg = 0;
    check_index1 = 0; check_index2 = 0;
    tick(); tick();
    check_eq("rst_we", write_enable, 0);
    check_eq("rst_reg", write_reg, 0);
    check_eq("rst_data", write_data, 0);
    check_eq("rst_ready", ch1_ready, 1);
    check_eq("rst_idle", idle, 1);
    reset = 1'b1;
    tick();

    // Single ch0 write, then hold behaviour
    ch0_valid = 1; ch0_reg = 5; ch0_data = 32'h1234;
    tick();
    ch0_valid = 0; check_index1 = 5;
    #1;
    check_eq("ch0_we", write_enable, 1);
    check_eq("ch0_reg", write_reg, 5);
    check_eq("ch0_data", write_data, 32'h1234);
    check_eq("ch0_busy_stage", busy1, 1);
    tick();
    check_eq("hold_we", write_enable, 0);
    check_eq("hold_reg", write_reg, 5);
    check_eq("hold_data", write_data, 32'h1234);
    check_eq("hold_busy", busy1, 0);
    check_eq("hold_idle", idle, 1);

    // ch0 and ch1 together for 3 cycles, then drain
    for (int i = 0; i < 3; i++) begin
      ch0_valid = 1; ch0_reg = 3; ch0_data = 32'h30 + i;
      ch1_valid = 1; ch1_reg = 4; ch1_data = 32'h40 + i;
      #1;
      check_eq($sformatf("mix_ready%0d", i), ch1_ready, (i < 2) ? 1 : 0);
      tick();
      check_eq($sformatf("mix_we%0d", i), write_enable, 1);
      check_eq($sformatf("mix_reg%0d", i), write_reg, 3);
      check_eq($sformatf("mix_data%0d", i), write_data, 32'h30 + i);
    end
    ch0_valid = 0; ch1_valid = 0;
    tick();
    check_eq("drain0_we", write_enable, 1);
    check_eq("drain0_reg", write_reg, 4);
    check_eq("drain0_data", write_data, 32'h40);
    check_eq("drain0_ready", ch1_ready, 1);
    tick();
    check_eq("drain1_we", write_enable, 1);
    check_eq("drain1_reg", write_reg, 4);
    check_eq("drain1_data", write_data, 32'h41);
    tick();
    check_eq("drain_done_we", write_enable, 0);
    check_eq("drain_done_idle", idle, 1);

    // Reserve reg 7, retire via ch1
    reserve_valid = 1; reserve_reg = 7;
    tick();
    reserve_valid = 0; check_index1 = 7;
    #1;
    check_eq("rsv7_busy", busy1, 1);
    check_eq("rsv7_idle", idle, 0);
    ch1_valid = 1; ch1_reg = 7; ch1_data = 32'h77;
    tick();
    ch1_valid = 0;
    #1;
    check_eq("rsv7_busy_queued", busy1, 1);
    tick();
    check_eq("rsv7_we", write_enable, 1);
    check_eq("rsv7_reg", write_reg, 7);
    check_eq("rsv7_data", write_data, 32'h77);
    check_eq("rsv7_busy_stage", busy1, 1);
    tick();
    check_eq("rsv7_busy_clear", busy1, 0);
    check_eq("rsv7_idle_after", idle, 1);

    // Register 0 write is suppressed
    ch0_valid = 1; ch0_reg = 0; ch0_data = 32'hFFFF_FFFF;
    check_index1 = 0; check_index2 = 0;
    tick();
    ch0_valid = 0;
    #1;
    check_eq("r0_we", write_enable, 0);
    check_eq("r0_busy1", busy1, 0);
    check_eq("r0_busy2", busy2, 0);
    check_eq("r0_idle", idle, 1);

    // Reserve and write reg 9 in the same cycle: reservation survives
    reserve_valid = 1; reserve_reg = 9;
    ch0_valid = 1; ch0_reg = 9; ch0_data = 32'h99;
    check_index2 = 9;
    tick();
    reserve_valid = 0; ch0_valid = 0;
    #1;
    check_eq("r9_we", write_enable, 1);
    check_eq("r9_reg", write_reg, 9);
    check_eq("r9_busy", busy2, 1);
    tick();
    check_eq("r9_pending", busy2, 1);
    check_eq("r9_idle", idle, 0);
    ch0_valid = 1; ch0_reg = 9; ch0_data = 32'h9A;
    tick();
    ch0_valid = 0;
    tick();
    check_eq("r9_cleared", busy2, 0);
    check_eq("r9_idle_after", idle, 1);

    // Fill FIFO, then reset mid-operation
    for (int i = 0; i < 2; i++) begin
      ch0_valid = 1; ch0_reg = 2; ch0_data = 32'h20 + i;
      ch1_valid = 1; ch1_reg = 6; ch1_data = 32'h60 + i;
      tick();
    end
    check_eq("full_ready", ch1_ready, 0);
    reset = 0; reserve_valid = 1; reserve_reg = 12; check_index1 = 12;
    tick();
    check_eq("mid_rst_we", write_enable, 0);
    check_eq("mid_rst_ready", ch1_ready, 1);
    check_eq("mid_rst_idle", idle, 1);
    check_eq("mid_rst_busy", busy1, 0);
    reset = 1; ch0_valid = 0; ch1_valid = 0; reserve_valid = 0;
    #1;
    check_eq("post_rst_ready", ch1_ready, 1);
    check_eq("post_rst_idle", idle, 1);
    tick();
    check_eq("no_stale_we0", write_enable, 0);
    tick();
    check_eq("no_stale_we1", write_enable, 0);
    check_eq("no_stale_idle", idle, 1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/writeback_sequencer.md
WRITEBACK_SEQUENCER -- requirements
Module: writeback_sequencer

Interface
REQ-001 SHALL have parameter FIFO_DEPTH, default 2, depth of the ch1 holding FIFO (power of two, >=2).
REQ-002 SHALL have port clk  input  1  single clock; all state changes on posedge clk.
REQ-003 SHALL have port reset  input  1  synchronous, active-low reset (asserted when 0, sampled on posedge clk).
REQ-004 SHALL have ports ch0_valid input 1, ch0_reg input 5, ch0_data input 32: ALU result channel, always accepted.
REQ-005 SHALL have ports ch1_valid input 1, ch1_ready output 1, ch1_reg input 5, ch1_data input 32: load/mult result channel, valid/ready handshake.
REQ-006 SHALL have ports reserve_valid input 1, reserve_reg input 5: issue-time destination reservation.
REQ-007 SHALL have ports check_index1 input 5, check_index2 input 5, busy1 output 1, busy2 output 1: hazard query.
REQ-008 SHALL have ports write_enable output 1, write_reg output 5, write_data output 32: register-file write port drive.
REQ-009 SHALL have port idle output 1: high when FIFO empty, no write in flight and scoreboard clear.

Function
REQ-010 SHALL accept ch0 on every cycle ch0_valid=1; ch0 has priority over the FIFO head.
REQ-011 SHALL complete a ch1 transfer on a cycle where ch1_valid=1 and ch1_ready=1, pushing {reg,data} into the FIFO.
REQ-012 SHALL drive ch1_ready = FIFO not full, combinationally from registered count only (no dependence on ch1_valid).
REQ-013 SHALL pop the FIFO head into the write stage only on a cycle with ch0_valid=0; FIFO order is strictly FIFO.
REQ-014 SHALL permit simultaneous push and pop when full-minus-zero (full) only via pop-first-then-ready next cycle; push while full never occurs since ch1_ready=0.
REQ-015 SHALL register the selected write: write_enable/write_reg/write_data valid exactly 1 cycle after ch0 acceptance or FIFO pop.
REQ-016 SHALL suppress write_enable for destination register 0, while still completing the handshake/pop and clearing nothing.
REQ-017 SHALL hold write_enable=0 on cycles with no selected source; write_reg/write_data then hold previous values.
REQ-018 SHALL keep a 32-bit pending scoreboard; reserve_valid=1 with reserve_reg!=0 sets bit reserve_reg on next edge.
REQ-019 SHALL clear a pending bit on the edge where the corresponding write is selected (same edge write_enable is registered high).
REQ-020 SHALL let set win over clear when reservation and write target the same register in the same cycle.
REQ-021 SHALL drive busy1/busy2 combinationally = pending[check_index] OR (write stage register holds write_enable=1 to that index); index 0 always not busy.
REQ-022 SHALL treat reservation of an already-pending register as no-op (bit stays set).
REQ-023 SHALL use FIFO pointers of log2(FIFO_DEPTH) bits wrapping modulo depth, plus a count of log2(FIFO_DEPTH)+1 bits.

Reset
REQ-024 SHALL, while reset=0 at posedge clk, clear FIFO count and pointers, scoreboard, write_enable, write_reg and write_data to 0.
REQ-025 SHALL discard any FIFO contents and in-flight write on reset mid-operation; ch1_ready=1 and idle=1 on the first cycle after reset release.
REQ-026 SHALL ignore ch0_valid, ch1_valid and reserve_valid on cycles where reset=0.

Structure
REQ-027 SHALL place REG_IDX_W=5, DATA_W=32, NUM_REGS=32 and a packed wb_entry_t {reg, data} typedef in shared package mips_cpu_pkg.
REQ-028 SHALL instantiate one sub-module, wb_fifo (parameterised synchronous FIFO of wb_entry_t with full/empty/count).
REQ-029 SHALL contain no combinational path from ch1_valid to ch1_ready or from ch0 inputs to write outputs.

Verification
REQ-030 SHALL cover: ch0_valid, reg=5, data=0x1234 -> next cycle write_enable=1, write_reg=5, write_data=0x1234.
REQ-031 SHALL cover: ch0 and ch1 valid together (reg 3 / reg 4) for 3 cycles -> ch0 writes 3 cycles, ch1_ready drops after 2 pushes, then two reg-4 writes drain in order.
REQ-032 SHALL cover: reserve reg 7, query check_index1=7 -> busy1=1 until ch1 write to reg 7 emitted, then busy1=0 next cycle.
REQ-033 SHALL cover: ch0 write to reg 0 with data 0xFFFFFFFF -> write_enable stays 0, busy for index 0 always 0.
REQ-034 SHALL cover: FIFO full, reset=0 one cycle -> write_enable=0, ch1_ready=1, idle=1, no stale FIFO write afterwards.
REQ-035 SHALL cover: reserve reg 9 and ch0 write to reg 9 same cycle -> pending[9] remains 1 after the write.
